// File: rtl/tt_cell_host_ctrl.sv
// tt_cell_host_ctrl: host-side serial master for the cell macro control pads.
// Turns one parallel request into a framed hclk/hsig transaction and, for
// reads, turns the bus around and shifts in the data the cell returns.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame; hclk parked low, hsig driven low, ready for a request
// HDR   | shifting out START, RW and ADDR
// WR    | shifting out WDATA
// TA    | turnaround, hsig released, nothing sampled
// RD    | hsig released, one data bit sampled per period
// STOP  | hsig reclaimed and driven low for one period, then done
module tt_cell_host_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int TA_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              hclk_o,
  output logic              hsig_o,
  output logic              hsig_oe,
  input  logic              hsig_i
);

  localparam int HDR_BITS = 2 + ADDR_W;
  localparam int MAX_BITS = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
  localparam int BCW      = $clog2(MAX_BITS) + 1;
  localparam int DIVW     = $clog2(CLK_DIV) + 1;
  // START is emitted directly on accept, so only RW/ADDR/WDATA are held here
  localparam int TXW      = 1 + ADDR_W + DATA_W;

  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [BCW-1:0]  HDR_LAST  = BCW'(HDR_BITS - 1);
  localparam logic [BCW-1:0]  DATA_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0]  TA_LAST   = BCW'(TA_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WR,
    S_TA,
    S_RD,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic              phase_hi_q, phase_hi_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic [TXW-1:0]    tx_q, tx_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              done_q, done_d;
  logic              hclk_q, hclk_d;
  logic              hsig_q, hsig_d;
  logic              oe_q, oe_d;
  logic [1:0]        sync_q;

  // hsig_i is asynchronous to clk; two flops before anything looks at it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], hsig_i};
  end

  // Sequencer registers; every pad-facing output comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_hi_q <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      wr_q       <= 1'b0;
      rx_q       <= '0;
      rsp_q      <= '0;
      done_q     <= 1'b0;
      hclk_q     <= 1'b0;
      hsig_q     <= 1'b0;
      oe_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_hi_q <= phase_hi_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      wr_q       <= wr_d;
      rx_q       <= rx_d;
      rsp_q      <= rsp_d;
      done_q     <= done_d;
      hclk_q     <= hclk_d;
      hsig_q     <= hsig_d;
      oe_q       <= oe_d;
    end
  end

  // Next-state: phase timer, bit counter, frame sequencing and pad values
  always_comb begin
    state_d    = state_q;
    phase_hi_d = phase_hi_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    wr_d       = wr_q;
    rx_d       = rx_q;
    rsp_d      = rsp_q;
    done_d     = 1'b0;
    hclk_d     = hclk_q;
    hsig_d     = hsig_q;
    oe_d       = oe_q;

    if (state_q == S_IDLE) begin
      hclk_d = 1'b0;
      hsig_d = 1'b0;
      oe_d   = 1'b1;
      if (req_valid) begin
        // first low phase starts next cycle with START already on hsig
        state_d    = S_HDR;
        phase_hi_d = 1'b0;
        div_d      = DIV_LAST;
        bit_d      = HDR_LAST;
        tx_d       = {req_write, req_addr, req_wdata};
        wr_d       = req_write;
        hsig_d     = 1'b1;
      end
    end else if (div_q != '0) begin
      div_d = div_q - 1'b1;
    end else if (!phase_hi_q) begin
      phase_hi_d = 1'b1;
      hclk_d     = 1'b1;
      div_d      = DIV_LAST;
    end else begin
      // last cycle of the high phase: sample, then open the next low phase
      phase_hi_d = 1'b0;
      hclk_d     = 1'b0;
      div_d      = DIV_LAST;
      if (state_q == S_RD) rx_d = {rx_q[DATA_W-2:0], sync_q[1]};

      if (bit_q != '0) begin
        bit_d = bit_q - 1'b1;
        if (state_q == S_HDR || state_q == S_WR) begin
          hsig_d = tx_q[TXW-1];
          tx_d   = tx_q << 1;
        end
      end else begin
        case (state_q)
          S_HDR: begin
            if (wr_q) begin
              state_d = S_WR;
              bit_d   = DATA_LAST;
              hsig_d  = tx_q[TXW-1];
              tx_d    = tx_q << 1;
            end else begin
              // release the line; hsig_o is parked low while not driven
              state_d = S_TA;
              bit_d   = TA_LAST;
              hsig_d  = 1'b0;
              oe_d    = 1'b0;
            end
          end
          S_TA: begin
            state_d = S_RD;
            bit_d   = DATA_LAST;
          end
          S_WR, S_RD: begin
            state_d = S_STOP;
            bit_d   = '0;
            hsig_d  = 1'b0;
            oe_d    = 1'b1;
          end
          S_STOP: begin
            state_d = S_IDLE;
            bit_d   = '0;
            hsig_d  = 1'b0;
            oe_d    = 1'b1;
            done_d  = 1'b1;
            if (!wr_q) rsp_d = rx_q;
          end
          default: begin
            state_d = S_IDLE;
            bit_d   = '0;
            hsig_d  = 1'b0;
            oe_d    = 1'b1;
          end
        endcase
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = !req_ready;
  assign done      = done_q;
  assign rsp_rdata = rsp_q;
  assign hclk_o    = hclk_q;
  assign hsig_o    = hsig_q;
  assign hsig_oe   = oe_q;

endmodule

// File: tb/tb_tt_cell_host_ctrl.sv
// Directed plus randomized bench for tt_cell_host_ctrl at default parameters.
// A monitor records (hsig_oe, hsig_o) at every rising hclk; a cell model
// drives read data on hsig_i while the host has released the line.
module tb_tt_cell_host_ctrl;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 4;
  localparam int TA_CYC  = 1;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              done;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              hclk_o;
  logic              hsig_o;
  logic              hsig_oe;
  logic              hsig_i;

  int n_pass = 0;
  int n_chk  = 0;

  logic [63:0]       cap_sig = '0;
  logic [63:0]       cap_oe  = '0;
  int                cap_n   = 0;
  logic [DATA_W-1:0] rd_val  = '0;
  logic [DATA_W-1:0] prev_rdata = '0;
  int                ta_k    = 0;
  logic              exp_w   = 1'b0;
  logic [ADDR_W-1:0] exp_a   = '0;
  logic [DATA_W-1:0] exp_d   = '0;

  tt_cell_host_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV),
    .TA_CYC (TA_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .done     (done),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .hclk_o   (hclk_o),
    .hsig_o   (hsig_o),
    .hsig_oe  (hsig_oe),
    .hsig_i   (hsig_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // record the bus at every rising hclk
  initial begin
    forever begin
      @(posedge hclk_o);
      #1;
      cap_sig = {cap_sig[62:0], hsig_o};
      cap_oe  = {cap_oe[62:0], hsig_oe};
      cap_n++;
    end
  end

  // cell model: new bit at each low-phase start while the host has released hsig
  initial begin
    hsig_i = 1'b0;
    forever begin
      @(negedge hclk_o);
      #1;
      if (hsig_oe === 1'b0) begin
        if (ta_k >= TA_CYC && ta_k < TA_CYC + DATA_W)
          hsig_i = rd_val[DATA_W-1-(ta_k-TA_CYC)];
        else
          hsig_i = ($urandom_range(0, 1) != 0);
        ta_k++;
      end else begin
        hsig_i = ($urandom_range(0, 1) != 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    exp_w     = w;
    exp_a     = a;
    exp_d     = d;
    rd_val    = 16'($urandom);
    ta_k      = 0;
    cap_sig   = '0;
    cap_oe    = '0;
    cap_n     = 0;
  endtask

  // called at a negedge with a request presented; returns at the done negedge
  // (hold=1) or one cycle later (hold=0)
  task automatic run_txn(input bit hold, input bit corrupt, input string tag);
    int          n;
    int          ep;
    logic [63:0] es;
    logic [63:0] eo;
    chk({tag, "_ready"}, 64'(req_ready), 64'(1'b1));
    @(negedge clk);
    chk({tag, "_start"}, 64'({hclk_o, hsig_o, hsig_oe, req_ready, busy, done}), 64'(6'b011010));
    if (!hold) req_valid = 1'b0;
    if (corrupt) begin
      req_addr  = ~exp_a;
      req_wdata = ~exp_d;
      req_write = ~exp_w;
    end
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ep = 2 + ADDR_W + (exp_w ? DATA_W : TA_CYC + DATA_W) + 1;
    if (exp_w) begin
      es = 64'({1'b1, 1'b1, exp_a, exp_d, 1'b0});
      eo = 64'({25{1'b1}});
    end else begin
      es = 64'({1'b1, 1'b0, exp_a, 17'd0, 1'b0});
      eo = 64'({8'hFF, 17'd0, 1'b1});
      prev_rdata = rd_val;
    end
    chk({tag, "_latency"}, 64'(n), 64'(ep * 2 * CLK_DIV));
    chk({tag, "_periods"}, 64'(cap_n), 64'(ep));
    chk({tag, "_bits"}, cap_sig, es);
    chk({tag, "_oe"}, cap_oe, eo);
    chk({tag, "_done_ready"}, 64'({done, req_ready, busy}), 64'(3'b110));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(prev_rdata));
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'({done, req_ready, hclk_o}), 64'(3'b010));
    end
  endtask

  initial begin
    logic saw_done;
    logic saw_hclk;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({hclk_o, hsig_o, hsig_oe, req_ready, busy, done}), 64'(6'b001100));
    chk("reset_rdata", 64'(rsp_rdata), 64'(0));
    rst = 1'b0;

    saw_done = 1'b0;
    saw_hclk = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_done |= done;
      saw_hclk |= hclk_o;
    end
    chk("idle_outs", 64'({hclk_o, hsig_o, hsig_oe, req_ready, busy}), 64'(5'b00110));
    chk("idle_no_done_hclk", 64'({saw_done, saw_hclk}), 64'(2'b00));

    start_req(1'b1, 6'h2A, 16'hBEEF);
    run_txn(1'b0, 1'b0, "wr_beef");

    start_req(1'b0, 6'h05, 16'h0000);
    rd_val = 16'hA55A;
    run_txn(1'b0, 1'b0, "rd_a55a");

    start_req(1'b1, 6'h11, 16'h1234);
    run_txn(1'b0, 1'b0, "wr_keep_rdata");

    start_req(1'b1, 6'h3C, 16'h0F0F);
    run_txn(1'b1, 1'b0, "b2b_0");
    start_req(1'b0, 6'h21, 16'h0000);
    run_txn(1'b1, 1'b0, "b2b_1");
    start_req(1'b1, 6'h07, 16'h8001);
    run_txn(1'b0, 1'b0, "b2b_2");

    start_req(1'b1, 6'h15, 16'h5A3C);
    run_txn(1'b0, 1'b1, "capt_wr");
    start_req(1'b0, 6'h2B, 16'h0000);
    run_txn(1'b0, 1'b1, "capt_rd");

    // reset in the middle of the address field of a write
    start_req(1'b1, 6'h3F, 16'hFFFF);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_pre", 64'({hclk_o, hsig_o, hsig_oe, busy}), 64'(4'b1111));
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", 64'({hclk_o, hsig_o, hsig_oe, req_ready, busy, done}), 64'(6'b001100));
    chk("rst_async_rdata", 64'(rsp_rdata), 64'(0));
    prev_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    saw_hclk = 1'b0;
    repeat (250) begin
      @(negedge clk);
      saw_done |= done;
      saw_hclk |= hclk_o;
    end
    chk("rst_abandoned", 64'({saw_done, saw_hclk, req_ready}), 64'(3'b001));
    start_req(1'b0, 6'h2C, 16'h0000);
    run_txn(1'b0, 1'b0, "rd_after_rst");

    for (int i = 0; i < 8; i++) begin
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      bit                hold;
      bit                corrupt;
      w       = ($urandom_range(0, 1) != 0);
      a       = 6'($urandom);
      d       = 16'($urandom);
      corrupt = ($urandom_range(0, 1) != 0);
      hold    = (i != 7) && ($urandom_range(0, 1) != 0);
      start_req(w, a, d);
      run_txn(hold, corrupt, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_cell_host_ctrl.md
Name: tt_cell_host_ctrl

Overview:
- Host-side serial master for the cell macro control interface.
- Generates the hclk/hsig pair that cell macros receive through their pads.
- Serialises write and read transactions onto hsig and, for reads, releases hsig and samples the data the cell returns.
- Sits in the top-level controller between a parallel request/response port and the hclk/hsig pad drivers.

Parameters:
- ADDR_W, 6, address bits per frame.
- DATA_W, 16, data bits per frame.
- CLK_DIV, 4, clk cycles per hclk half-period; legal values are >= 3.
- TA_CYC, 1, turnaround hclk periods in a read, during which nobody drives hsig.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target address.
- req_wdata  input  DATA_W  write data.
- done  output  1  one-cycle pulse when a transaction completes.
- rsp_rdata  output  DATA_W  last read data; held until the next read completes.
- busy  output  1  a frame is in progress.
- hclk_o  output  1  serial clock to the pad.
- hsig_o  output  1  serial data to the pad.
- hsig_oe  output  1  pad output enable for hsig.
- hsig_i  input  1  serial data from the pad (asynchronous).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - hclk_o=0, hsig_o=0, hsig_oe=1, req_ready=1, busy=0, done=0, rsp_rdata=0.
  - State IDLE, all counters 0.
- Reset asserted mid-frame:
  - All outputs go to their reset values immediately.
  - The frame is abandoned and no done pulse is issued.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on the clk edge where req_valid && req_ready.
  - req_write, req_addr and req_wdata are captured on that edge; later changes to them are ignored.
- hclk timing:
  - One bit period is 2*CLK_DIV clk cycles: low phase of CLK_DIV cycles, then high phase of CLK_DIV cycles.
  - The first low phase begins in the cycle after acceptance.
  - hsig_o changes only at the start of a low phase.
- Input sampling:
  - hsig_i passes through a 2-flop synchroniser.
  - The synchronised value is sampled in the last clk cycle of each high phase.
- Frame layout, MSB first:
  - START (1 bit, value 1).
  - RW (1 bit, req_write).
  - ADDR (ADDR_W bits).
  - Write: WDATA (DATA_W bits).
  - Read: TA (TA_CYC periods), then RDATA (DATA_W periods).
  - STOP (1 period, hsig_o=0).
- Bus ownership:
  - hsig_oe=1 during START, RW, ADDR, WDATA and STOP.
  - hsig_oe=0 during TA and RDATA; hsig_o=0 whenever hsig_oe=0.
  - hsig_oe returns to 1 at the start of the STOP low phase.
- States and transitions:
  - IDLE -> HDR on accept.
  - HDR -> WR or TA after 2+ADDR_W bits.
  - WR -> STOP after DATA_W bits.
  - TA -> RD after TA_CYC periods.
  - RD -> STOP after DATA_W bits.
  - STOP -> IDLE at the end of its high phase.
- Bit counter:
  - Width is clog2 of max(2+ADDR_W, DATA_W) + 1.
  - Reloads on every state change; it has no wrap-around use.
- Read data:
  - RD bits shift into a DATA_W register, MSB first.
  - rsp_rdata is updated from that register in the same cycle done pulses for a read.
  - rsp_rdata is unchanged after a write.
- Completion:
  - done=1 for exactly one cycle on the STOP->IDLE transition.
  - req_ready rises in that same cycle.
  - A new request may be accepted in that cycle; back-to-back frames have no extra idle periods.
- busy = !req_ready.
- Latency at defaults (CLK_DIV=4, ADDR_W=6, DATA_W=16):
  - Write: 25 periods = 200 clk from acceptance to done.
  - Read (TA_CYC=1): 26 periods = 208 clk.
- hclk_o is 0 in IDLE; no hclk edges are generated between frames.

Test Plan:
- Reset, then idle 20 cycles -> hclk_o=0, hsig_o=0, hsig_oe=1, req_ready=1, done never set.
- Write addr=0x2A, data=0xBEEF -> hsig bits 1,1,101010,1011111011101111,0 at rising hclk.
  - Check: done at clk 200 after accept; hsig_oe=1 throughout.
- Read addr=0x05, model drives 0xA55A on hsig_i while hsig_oe=0 -> hsig_oe=0 for exactly 17 periods.
  - Check: rsp_rdata=0xA55A with done at clk 208.
  - Check: rsp_rdata unchanged after a subsequent write.
- Two requests back-to-back (req_valid held high) -> second accepted in the done cycle; next START low phase begins the following cycle.
- rst pulsed mid-ADDR of a write -> outputs return to reset values asynchronously, no done; a following read completes normally.
- req_addr and req_wdata changed one cycle after accept -> transmitted bits match the captured values.
